// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and constants for the ID-stage load-use scoreboard.
package reg_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned DEPTH_DEF      = 3;
  localparam int unsigned LOAD_READY_DEF = 2;
  localparam int unsigned CNT_W_DEF      = 16;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard_slot_cmp.sv
// Compares one in-flight scoreboard slot against both ID read ports for a load-use hazard.
module reg_scoreboard_slot_cmp
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned SLOT_IDX   = 0,
  parameter int unsigned LOAD_READY = LOAD_READY_DEF
) (
  input  logic                  slot_v,
  input  logic                  slot_ld,
  input  logic [REG_ADDR_W-1:0] slot_addr,
  input  logic                  read_en_1,
  input  logic [REG_ADDR_W-1:0] addr_1,
  input  logic                  read_en_2,
  input  logic [REG_ADDR_W-1:0] addr_2,
  output logic                  match_1,
  output logic                  match_2
);

  // Slot k sits k+1 stages ahead of ID; LOAD_READY counts stages from ID, so only
  // a load still in EX (distance 1) blocks an immediately dependent instruction.
  localparam bit NotReady = (SLOT_IDX + 1) < LOAD_READY;

  logic live_load;

  assign live_load = NotReady & slot_v & slot_ld;

  assign match_1 = live_load & read_en_1 & (slot_addr == addr_1) &
                   (addr_1 != REG_ADDR_W'(REG_ZERO));
  assign match_2 = live_load & read_en_2 & (slot_addr == addr_2) &
                   (addr_2 != REG_ADDR_W'(REG_ZERO));

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage hazard controller: load-use stalls, memory-wait freezes and deferred flushes.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned LOAD_READY = LOAD_READY_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  id_read_en_1,
  input  logic                  id_read_en_2,
  input  logic [REG_ADDR_W-1:0] id_addr_1,
  input  logic [REG_ADDR_W-1:0] id_addr_2,
  input  logic                  id_write_en,
  input  logic [REG_ADDR_W-1:0] id_write_addr,
  input  logic                  id_is_load,
  input  logic                  mem_stall_req,
  input  logic                  flush_req,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  freeze_all,
  output logic                  flush_out,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] addr;
    logic                  ld;
  } slot_t;

  localparam slot_t SlotEmpty = '0;

  slot_t            slot_q [DEPTH];
  slot_t            slot_d [DEPTH];
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] match_1, match_2;
  logic             hazard;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    reg_scoreboard_slot_cmp #(
      .REG_ADDR_W (REG_ADDR_W),
      .SLOT_IDX   (k),
      .LOAD_READY (LOAD_READY)
    ) u_cmp (
      .slot_v    (slot_q[k].v),
      .slot_ld   (slot_q[k].ld),
      .slot_addr (slot_q[k].addr),
      .read_en_1 (id_read_en_1),
      .addr_1    (id_addr_1),
      .read_en_2 (id_read_en_2),
      .addr_2    (id_addr_2),
      .match_1   (match_1[k]),
      .match_2   (match_2[k])
    );
  end

  assign hazard = id_valid & ((|match_1) | (|match_2));

  // Outputs are gated by rst_n so the pipeline sees no control activity during reset.
  always_comb begin
    freeze_all = rst_n & mem_stall_req;
    flush_out  = rst_n & ~mem_stall_req & (flush_req | flush_pend_q);
    stall_id   = rst_n & ~mem_stall_req & ~flush_out & hazard;
    bubble_ex  = stall_id;
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      slot_d[k] = slot_q[k];
    end
    flush_pend_d = flush_pend_q;
    if (freeze_all) begin
      // A flush arriving while frozen is remembered until the pipe can move.
      flush_pend_d = flush_pend_q | flush_req;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[0]    = SlotEmpty;
      flush_pend_d = 1'b0;
      if (!flush_out && !stall_id && id_valid && id_write_en &&
          (id_write_addr != REG_ADDR_W'(REG_ZERO))) begin
        slot_d[0] = '{v: 1'b1, addr: id_write_addr, ld: id_is_load};
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall_id || freeze_all) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= SlotEmpty;
      end
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed, table-driven bench for reg_scoreboard plus saturation and mid-run reset sequences.
module tb_reg_scoreboard;

  localparam int T0 = 8;
  localparam int T1 = 9;
  localparam int T2 = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_read_en_1, id_read_en_2;
  logic [4:0]  id_addr_1, id_addr_2, id_write_addr;
  logic        id_write_en, id_is_load;
  logic        mem_stall_req, flush_req;
  logic        stall_id, bubble_ex, freeze_all, flush_out;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_read_en_1  (id_read_en_1),
    .id_read_en_2  (id_read_en_2),
    .id_addr_1     (id_addr_1),
    .id_addr_2     (id_addr_2),
    .id_write_en   (id_write_en),
    .id_write_addr (id_write_addr),
    .id_is_load    (id_is_load),
    .mem_stall_req (mem_stall_req),
    .flush_req     (flush_req),
    .stall_id      (stall_id),
    .bubble_ex     (bubble_ex),
    .freeze_all    (freeze_all),
    .flush_out     (flush_out),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    logic        valid;
    logic        re1;
    logic [4:0]  a1;
    logic        re2;
    logic [4:0]  a2;
    logic        we;
    logic [4:0]  wa;
    logic        ld;
    logic        mem;
    logic        fl;
    logic        e_stall;
    logic        e_freeze;
    logic        e_flush;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int valid, input int re1, input int a1, input int re2,
                              input int a2, input int we, input int wa, input int ld,
                              input int mem, input int fl, input int es, input int efz,
                              input int efl, input int cnt);
    vec_t v;
    v.valid = valid[0]; v.re1 = re1[0]; v.a1 = a1[4:0]; v.re2 = re2[0]; v.a2 = a2[4:0];
    v.we = we[0]; v.wa = wa[4:0]; v.ld = ld[0]; v.mem = mem[0]; v.fl = fl[0];
    v.e_stall = es[0]; v.e_freeze = efz[0]; v.e_flush = efl[0]; v.e_cnt = cnt[15:0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_read_en_1 = v.re1; id_addr_1 = v.a1;
    id_read_en_2 = v.re2; id_addr_2 = v.a2; id_write_en = v.we;
    id_write_addr = v.wa; id_is_load = v.ld; mem_stall_req = v.mem; flush_req = v.fl;
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " stall_id"}, 32'(stall_id), 32'(v.e_stall));
    chk({tag, " bubble_ex"}, 32'(bubble_ex), 32'(v.e_stall));
    chk({tag, " freeze_all"}, 32'(freeze_all), 32'(v.e_freeze));
    chk({tag, " flush_out"}, 32'(flush_out), 32'(v.e_flush));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(v.e_cnt));
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use: one stall, then the dependent is accepted.
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, T2, 0, 0, 1, T0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, T0, 1, T2, 1, T1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, T0, 1, T2, 1, T1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Non-load producer is forwarded, never stalls.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, T0, 1, T0, 1, T1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Load to $zero then read of $zero.
    vecs.push_back(mk(1, 1, T2, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // id_valid gating, two-behind no stall, port-2 match, read-enable gating.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T2, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, T2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, T2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, T1, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, T1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T1, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, T1, 0, T1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    // Three-cycle freeze with a load in EX: slots hold, stall follows.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T0, 1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    // Flush during freeze is deferred to the first free cycle; ID load is dropped.
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T0, 1, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 6));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 7));
    vecs.push_back(mk(1, 1, T0, 0, 0, 1, T1, 1, 0, 0, 0, 0, 1, 8));
    vecs.push_back(mk(1, 1, T1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    // Plain flush, then flush overriding a hazard.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, T0, 1, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 8));
    vecs.push_back(mk(1, 1, T0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));

    rst_n = 1'b0;
    drive(idle);
    #3;
    chk_outs("reset", idle);
    #9 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i]);
      #3 chk_outs($sformatf("v%0d", i), vecs[i]);
    end

    // Long freeze drives the counter from 8 to saturation.
    @(posedge clk);
    #1 drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    repeat (65526) @(posedge clk);
    #1 chk("sat pre", 32'(stall_cnt), 32'hFFFE);
    @(posedge clk);
    #1 chk("sat hit", 32'(stall_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1 chk("sat hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat freeze", 32'(freeze_all), 32'h1);

    // Fill all slots with loads, then reset mid-operation.
    drive(mk(1, 0, 0, 0, 0, 1, T0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 drive(mk(1, 0, 0, 0, 0, 1, T1, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 drive(mk(1, 0, 0, 0, 0, 1, T2, 1, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    v = mk(1, 1, T2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'hFFFF);
    #1 drive(v);
    #2 chk_outs("full", v);
    drive(mk(1, 1, T2, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1 chk_outs("midrst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    v = mk(1, 1, T2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    #3 chk_outs("postrst", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
